// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM test sequencer.
// The optional SDRAM_TEST_SEQ_CONT_EN macro (used by the top) selects looping passes.
package sdram_test_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        GAP      = 3'd2,
        WAIT_RDY = 3'd3,
        READ     = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam int BURST_LEN_DEF   = 256;
    localparam int GAP_CYCLES_DEF  = 16;
    localparam int RDY_TIMEOUT_DEF = 65535;

    // Burst counter covers 1..4096 words; the timer covers gap and ready timeout.
    localparam int BURST_CNT_W = 13;
    localparam int TIMER_W     = 16;
    localparam int PASS_CNT_W  = 16;

endpackage

// File: rtl/sdram_test_seq_if.sv
// Sequencer-to-tester signal bundle; master is the sequencer, slave the tester side.
interface sdram_test_seq_if;
    import sdram_test_pkg::*;

    // Strobes are active-low and registered. rfifo_rd_en is low in a cycle only
    // when rfifo_rd_ready was sampled high at the clock edge that began that cycle;
    // each low cycle of either strobe moves exactly one word.
    logic                  start;
    logic                  rfifo_rd_ready;
    logic                  wfifo_wr_en;
    logic                  rfifo_rd_en;
    logic                  busy;
    logic                  pass_done;
    logic [PASS_CNT_W-1:0] pass_cnt;
    logic                  timeout_err;
    state_t                state;

    modport master (
        input  start, rfifo_rd_ready,
        output wfifo_wr_en, rfifo_rd_en, busy, pass_done, pass_cnt, timeout_err, state
    );

    modport slave (
        output start, rfifo_rd_ready,
        input  wfifo_wr_en, rfifo_rd_en, busy, pass_done, pass_cnt, timeout_err, state
    );

endinterface

// File: rtl/sdram_seq_cnt.sv
// Loadable down-counter with a terminal flag; holds at zero rather than wrapping.
module sdram_seq_cnt #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         term
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !term) begin
            count <= count - W'(1);
        end
    end

    assign term = (count == '0);

endmodule

// File: rtl/sdram_test_seq.sv
// SDRAM test sequencer: write burst, gap, wait for read data, read burst, count passes.
// Define SDRAM_TEST_SEQ_CONT_EN to loop passes continuously instead of single-shot.
module sdram_test_seq
    import sdram_test_pkg::*;
#(
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
    input logic              clock,
    input logic              rst,
    sdram_test_seq_if.master bus
);

    // Counters are loaded with length-1 and finish on reaching zero.
    localparam logic [BURST_CNT_W-1:0] BURST_LOAD = BURST_CNT_W'(BURST_LEN - 1);
    localparam logic [TIMER_W-1:0]     GAP_LOAD   = TIMER_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TIMER_W-1:0]     RDY_LOAD   = TIMER_W'((RDY_TIMEOUT > 0) ? RDY_TIMEOUT - 1 : 0);

    state_t               state;
    state_t               state_next;
    logic                 burst_load;
    logic                 burst_dec;
    logic                 burst_term;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_dec;
    logic                 timer_term;
    logic                 rd_issue;
    logic                 rd_all;
    logic                 timeout_set;
    logic                 wr_en_q;
    logic                 rd_en_q;
    logic                 busy_q;
    logic                 pass_done_q;
    logic [PASS_CNT_W-1:0] pass_cnt_q;
    logic                 timeout_q;

    sdram_seq_cnt #(.W(BURST_CNT_W)) u_burst_cnt (
        .clock    (clock),
        .rst      (rst),
        .load     (burst_load),
        .load_val (BURST_LOAD),
        .dec      (burst_dec),
        .term     (burst_term)
    );

    sdram_seq_cnt #(.W(TIMER_W)) u_timer_cnt (
        .clock    (clock),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .term     (timer_term)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        burst_load  = 1'b0;
        burst_dec   = 1'b0;
        timer_load  = 1'b0;
        timer_val   = RDY_LOAD;
        timer_dec   = 1'b0;
        rd_issue    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = WRITE;
                    burst_load = 1'b1;
                end
            end
            WRITE: begin
                burst_dec = 1'b1;
                if (burst_term) begin
                    timer_load = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_next = WAIT_RDY;
                        timer_val  = RDY_LOAD;
                        burst_load = 1'b1;
                    end else begin
                        state_next = GAP;
                        timer_val  = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                timer_dec = 1'b1;
                if (timer_term) begin
                    state_next = WAIT_RDY;
                    timer_load = 1'b1;
                    timer_val  = RDY_LOAD;
                    burst_load = 1'b1;
                end
            end
            WAIT_RDY: begin
                // The first read strobe is issued here so it lands in the first READ cycle.
                if (bus.rfifo_rd_ready) begin
                    state_next = READ;
                    rd_issue   = 1'b1;
                    burst_dec  = 1'b1;
                end else if (timer_term) begin
                    state_next  = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            READ: begin
                if (rd_all) begin
                    state_next = DONE;
                end else if (bus.rfifo_rd_ready) begin
                    rd_issue  = 1'b1;
                    burst_dec = 1'b1;
                end
            end
`ifdef SDRAM_TEST_SEQ_CONT_EN
            DONE: begin
                state_next = WRITE;
                burst_load = 1'b1;
            end
`else
            DONE: begin
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_en_q     <= 1'b1;
            rd_en_q     <= 1'b1;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            pass_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            rd_all      <= 1'b0;
        end else begin
            wr_en_q     <= (state_next != WRITE);
            rd_en_q     <= !rd_issue;
            busy_q      <= (state_next != IDLE);
            pass_done_q <= (state_next == DONE);
            if (state_next == DONE) begin
                pass_cnt_q <= pass_cnt_q + PASS_CNT_W'(1);
            end
            if (state == IDLE && bus.start) begin
                timeout_q <= 1'b0;
            end else if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            if (burst_load) begin
                rd_all <= 1'b0;
            end else if (rd_issue && burst_term) begin
                rd_all <= 1'b1;
            end
        end
    end

    assign bus.wfifo_wr_en = wr_en_q;
    assign bus.rfifo_rd_en = rd_en_q;
    assign bus.busy        = busy_q;
    assign bus.pass_done   = pass_done_q;
    assign bus.pass_cnt    = pass_cnt_q;
    assign bus.timeout_err = timeout_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_sdram_test_seq.sv
// Bench for sdram_test_seq: directed passes, ready pause, timeout, reset abort, zero gap.
module tb_sdram_test_seq;
    import sdram_test_pkg::*;

    localparam int BL    = 8;
    localparam int GAPC  = 4;
    localparam int TMO   = 20;
    localparam int REC_W = 100;

    // clock/reset block
    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    sdram_test_seq_if bus_a ();
    sdram_test_seq_if bus_b ();

    sdram_test_seq #(.BURST_LEN(BL), .GAP_CYCLES(GAPC), .RDY_TIMEOUT(TMO)) dut_a (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_a)
    );

    sdram_test_seq #(.BURST_LEN(BL), .GAP_CYCLES(0), .RDY_TIMEOUT(TMO)) dut_b (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_b)
    );

    int chk_cnt = 0;
    int err_cnt = 0;
    logic [REC_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Event record: kind(1=pass,2=timeout), write lows, gap cycles, wait cycles, read lows, read pauses, pass_cnt.
    function automatic logic [REC_W-1:0] mk_rec(input logic [3:0] kind, input logic [15:0] wr,
                                                input logic [15:0] gap, input logic [15:0] wt,
                                                input logic [15:0] rd, input logic [15:0] pause,
                                                input logic [15:0] pc);
        return {kind, wr, gap, wt, rd, pause, pc};
    endfunction

    // scoreboard monitor on dut_a
    logic [15:0] m_wr, m_gap, m_wait, m_rd, m_pause;
    logic        m_prev_ready;
    logic        m_prev_tmo;
    initial begin
        logic [REC_W-1:0] act;
        logic [REC_W-1:0] exp;
        m_wr = '0; m_gap = '0; m_wait = '0; m_rd = '0; m_pause = '0;
        m_prev_ready = 1'b0;
        m_prev_tmo   = 1'b0;
        forever begin
            @(negedge clock);
            if (rst) begin
                m_wr = '0; m_gap = '0; m_wait = '0; m_rd = '0; m_pause = '0;
                m_prev_tmo = 1'b0;
            end else begin
                if (!bus_a.wfifo_wr_en) m_wr++;
                if (bus_a.state == GAP) m_gap++;
                if (bus_a.state == WAIT_RDY) m_wait++;
                if (!bus_a.rfifo_rd_en) begin
                    m_rd++;
                    check("rd_en_without_ready", 32'(m_prev_ready), 32'd1);
                end
                if (bus_a.state == READ && bus_a.rfifo_rd_en) m_pause++;
                if (bus_a.pass_done || (bus_a.timeout_err && !m_prev_tmo)) begin
                    act = mk_rec(bus_a.pass_done ? 4'd1 : 4'd2, m_wr, m_gap, m_wait, m_rd, m_pause,
                                 bus_a.pass_cnt);
                    chk_cnt++;
                    if (exp_q.size() == 0) begin
                        err_cnt++;
                        $display("FAIL unexpected_event: got %0h expected no event", act);
                    end else begin
                        exp = exp_q.pop_front();
                        if (act !== exp) begin
                            err_cnt++;
                            $display("FAIL event_record: got %0h expected %0h", act, exp);
                        end
                    end
                    m_wr = '0; m_gap = '0; m_wait = '0; m_rd = '0; m_pause = '0;
                end
                m_prev_tmo = bus_a.timeout_err;
            end
            m_prev_ready = bus_a.rfifo_rd_ready;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    // sel: 0 pass_done, 1 timeout_err, 2 write strobe low, 3 read strobe low
    task automatic wait_a(input string name, input int sel, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clock);
            case (sel)
                0:       hit = bus_a.pass_done;
                1:       hit = bus_a.timeout_err;
                2:       hit = !bus_a.wfifo_wr_en;
                default: hit = !bus_a.rfifo_rd_en;
            endcase
        end
        if (!hit) begin
            chk_cnt++;
            err_cnt++;
            $display("FAIL %s: got no event in %0d cycles expected event", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit hit;
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_a.rfifo_rd_ready = 1'b0;
        bus_b.start = 1'b0;
        bus_b.rfifo_rd_ready = 1'b1;

        // reset state
        do_reset();
        check("rst_wr_en",     32'(bus_a.wfifo_wr_en), 32'd1);
        check("rst_rd_en",     32'(bus_a.rfifo_rd_en), 32'd1);
        check("rst_busy",      32'(bus_a.busy),        32'd0);
        check("rst_pass_done", 32'(bus_a.pass_done),   32'd0);
        check("rst_pass_cnt",  32'(bus_a.pass_cnt),    32'd0);
        check("rst_timeout",   32'(bus_a.timeout_err), 32'd0);
        check("rst_state",     32'(bus_a.state),       32'(IDLE));

        // basic pass, with a stray start mid-burst that must be ignored
        bus_a.rfifo_rd_ready = 1'b1;
        exp_q.push_back(mk_rec(4'd1, 16'd8, 16'd4, 16'd1, 16'd8, 16'd0, 16'd1));
        pulse_start_a();
        check("p1_busy",  32'(bus_a.busy),        32'd1);
        check("p1_wr_en", 32'(bus_a.wfifo_wr_en), 32'd0);
        tick();
        tick();
        pulse_start_a();
        wait_a("p1_done", 0, 100);
        tick();
        check("p1_done_one_cycle", 32'(bus_a.pass_done), 32'd0);
        check("p1_pass_cnt",       32'(bus_a.pass_cnt),  32'd1);

        // ready pause for 3 cycles after the 4th read strobe
        do_reset();
        bus_a.rfifo_rd_ready = 1'b1;
        exp_q.push_back(mk_rec(4'd1, 16'd8, 16'd4, 16'd1, 16'd8, 16'd3, 16'd1));
        pulse_start_a();
        for (int k = 0; k < 4; k++) wait_a("p2_read", 3, 100);
        tick();
        bus_a.rfifo_rd_ready = 1'b0;
        tick();
        tick();
        tick();
        bus_a.rfifo_rd_ready = 1'b1;
        wait_a("p2_done", 0, 100);

        // ready never arrives: timeout, then a new start clears the flag
        do_reset();
        bus_a.rfifo_rd_ready = 1'b0;
        exp_q.push_back(mk_rec(4'd2, 16'd8, 16'd4, 16'd20, 16'd0, 16'd0, 16'd0));
        pulse_start_a();
        wait_a("p3_timeout", 1, 200);
        check("p3_busy",     32'(bus_a.busy),     32'd0);
        check("p3_state",    32'(bus_a.state),    32'(IDLE));
        check("p3_pass_cnt", 32'(bus_a.pass_cnt), 32'd0);
        tick();
        tick();
        tick();
        check("p3_sticky", 32'(bus_a.timeout_err), 32'd1);
        bus_a.rfifo_rd_ready = 1'b1;
        exp_q.push_back(mk_rec(4'd1, 16'd8, 16'd4, 16'd1, 16'd8, 16'd0, 16'd1));
        pulse_start_a();
        check("p3_start_clears", 32'(bus_a.timeout_err), 32'd0);
        wait_a("p3_done", 0, 100);

        // reset during the 5th write cycle aborts the burst
        do_reset();
        bus_a.rfifo_rd_ready = 1'b1;
        pulse_start_a();
        for (int k = 0; k < 4; k++) wait_a("p4_write", 2, 50);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("p4_wr_en",     32'(bus_a.wfifo_wr_en), 32'd1);
        check("p4_busy",      32'(bus_a.busy),        32'd0);
        check("p4_pass_cnt",  32'(bus_a.pass_cnt),    32'd0);
        exp_q.push_back(mk_rec(4'd1, 16'd8, 16'd4, 16'd1, 16'd8, 16'd0, 16'd1));
        pulse_start_a();
        wait_a("p4_done", 0, 100);

        // zero gap: WAIT_RDY follows the last write strobe directly
        do_reset();
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        n = 0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clock);
            if (!bus_b.wfifo_wr_en) n++;
            else if (n > 0) hit = 1'b1;
        end
        check("b_wr_lows",  32'(n),           32'd8);
        check("b_no_gap",   32'(bus_b.state), 32'(WAIT_RDY));
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clock);
            hit = bus_b.pass_done;
        end
        check("b_pass_done", 32'(hit),            32'd1);
        check("b_pass_cnt",  32'(bus_b.pass_cnt), 32'd1);

`ifdef SDRAM_TEST_SEQ_CONT_EN
        // pass counter wrap and automatic re-entry into WRITE
        do_reset();
        bus_a.rfifo_rd_ready = 1'b1;
        exp_q.push_back(mk_rec(4'd1, 16'd8, 16'd4, 16'd1, 16'd8, 16'd0, 16'd0));
        pulse_start_a();
        force dut_a.pass_cnt_q = 16'hFFFF;
        tick();
        release dut_a.pass_cnt_q;
        wait_a("p6_done", 0, 100);
        @(negedge clock);
        check("p6_rewrite_state", 32'(bus_a.state),       32'(WRITE));
        check("p6_rewrite_wr_en", 32'(bus_a.wfifo_wr_en), 32'd0);
        check("p6_wrapped_cnt",   32'(bus_a.pass_cnt),    32'd0);
`endif

        do_reset();
        @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
